// File: rtl/tcp_conn_table_if.sv
// Valid/ready metadata channel shared by the connection-table ports.
// Payload width is set per instance.
interface metaIntf #(
  parameter int W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);
endinterface

// File: rtl/tcp_conn_table.sv
// Active-open / close broker between user and TCP stack.
// Keeps a sid-indexed table of remote-session ids and route ids.
module tcp_conn_table #(
  parameter int SESSION_ORDER = 10,
  parameter int RSID_BITS     = 14,
  parameter int ROUTE_BITS    = 14
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  metaIntf.s                       s_open_req,
  metaIntf.m                       m_open_req,
  metaIntf.s                       s_open_rsp,
  metaIntf.m                       m_open_rsp,
  metaIntf.s                       s_close_req,
  metaIntf.m                       m_close_req,
  input  logic [SESSION_ORDER-1:0] sid_addr,
  output logic [15:0]              rsid_out,
  output logic [ROUTE_BITS-1:0]    route_id_out,
  output logic [31:0]              open_ok_cnt,
  output logic [31:0]              open_fail_cnt
);

  localparam int VFID_BITS = 4;
  localparam int DEPTH     = 1 << SESSION_ORDER;
  localparam int OREQ_W    = 48 + RSID_BITS + ROUTE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RSP_WAIT,
    ST_CLOSE_SEND
  } state_t;

  state_t state_q, state_d;

  logic [31:0]            ip_q, ip_d;
  logic [15:0]            port_q, port_d;
  logic [VFID_BITS-1:0]   vfid_q, vfid_d;
  logic [RSID_BITS-1:0]   rsid_q, rsid_d;
  logic [ROUTE_BITS-1:0]  route_q, route_d;
  logic [15:0]            csid_q, csid_d;
  logic [31:0]            ok_q, ok_d;
  logic [31:0]            fail_q, fail_d;

  logic [15:0]            sess_ram [DEPTH];
  logic [ROUTE_BITS-1:0]  route_ram [DEPTH];
  logic [15:0]            rsid_rd_q;
  logic [ROUTE_BITS-1:0]  route_rd_q;

  logic [15:0] rsp_sid;
  logic        rsp_ok;
  logic        open_acc;
  logic        close_acc;
  logic        rsp_hs;
  logic        close_hs;
  logic        rsp_in_rng;
  logic        csid_in_rng;
  logic        ok_ev;
  logic        fail_ev;
  logic        sess_we;
  logic        route_we;
  logic [15:0] sess_wdata;
  logic [SESSION_ORDER-1:0] wr_idx;

  assign rsp_sid     = s_open_rsp.data[64:49];
  assign rsp_ok      = s_open_rsp.data[48];
  assign open_acc    = (state_q == ST_IDLE) && !s_close_req.valid
                       && s_open_req.valid;
  assign close_acc   = (state_q == ST_IDLE) && s_close_req.valid;
  assign rsp_hs      = (state_q == ST_RSP_WAIT) && s_open_rsp.valid
                       && m_open_rsp.ready;
  assign close_hs    = (state_q == ST_CLOSE_SEND) && m_close_req.ready;
  assign rsp_in_rng  = (rsp_sid >> SESSION_ORDER) == 16'd0;
  assign csid_in_rng = (csid_q >> SESSION_ORDER) == 16'd0;
  assign ok_ev       = rsp_hs && rsp_ok && rsp_in_rng;
  assign fail_ev     = rsp_hs && !(rsp_ok && rsp_in_rng);

  // Writes are gated by reset so an abandoned transaction never lands.
  assign sess_we    = aresetn && (ok_ev || (close_hs && csid_in_rng));
  assign route_we   = aresetn && ok_ev;
  assign sess_wdata = ok_ev ? 16'({2'b01, rsid_q}) : 16'h0000;
  assign wr_idx     = rsp_hs ? rsp_sid[SESSION_ORDER-1:0]
                             : csid_q[SESSION_ORDER-1:0];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_close_req.valid)     state_d = ST_CLOSE_SEND;
        else if (s_open_req.valid) state_d = ST_SEND;
      end
      ST_SEND:       if (m_open_req.ready)  state_d = ST_RSP_WAIT;
      ST_RSP_WAIT:   if (rsp_hs)            state_d = ST_IDLE;
      ST_CLOSE_SEND: if (m_close_req.ready) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_open_req.ready  = 1'b0;
    s_close_req.ready = 1'b0;
    m_open_req.valid  = 1'b0;
    m_open_req.data   = '0;
    s_open_rsp.ready  = 1'b0;
    m_open_rsp.valid  = 1'b0;
    m_open_rsp.data   = '0;
    m_close_req.valid = 1'b0;
    m_close_req.data  = '0;
    unique case (state_q)
      ST_IDLE: begin
        s_close_req.ready = s_close_req.valid;
        s_open_req.ready  = open_acc;
      end
      ST_SEND: begin
        m_open_req.valid = 1'b1;
        m_open_req.data  = {ip_q, port_q};
      end
      ST_RSP_WAIT: begin
        s_open_rsp.ready = m_open_rsp.ready;
        m_open_rsp.valid = s_open_rsp.valid;
        m_open_rsp.data  = {s_open_rsp.data, vfid_q};
      end
      ST_CLOSE_SEND: begin
        m_close_req.valid = 1'b1;
        m_close_req.data  = csid_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    ip_d    = ip_q;
    port_d  = port_q;
    vfid_d  = vfid_q;
    rsid_d  = rsid_q;
    route_d = route_q;
    csid_d  = csid_q;
    if (open_acc) begin
      ip_d    = s_open_req.data[OREQ_W-1 -: 32];
      port_d  = s_open_req.data[OREQ_W-33 -: 16];
      vfid_d  = s_open_req.data[ROUTE_BITS+RSID_BITS-1 -: VFID_BITS];
      rsid_d  = s_open_req.data[ROUTE_BITS +: RSID_BITS];
      route_d = s_open_req.data[ROUTE_BITS-1:0];
    end
    if (close_acc) csid_d = s_close_req.data;
    ok_d   = ok_q + {31'd0, ok_ev};
    fail_d = fail_q + {31'd0, fail_ev};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ip_q    <= '0;
      port_q  <= '0;
      vfid_q  <= '0;
      rsid_q  <= '0;
      route_q <= '0;
      csid_q  <= '0;
      ok_q    <= '0;
      fail_q  <= '0;
    end else begin
      ip_q    <= ip_d;
      port_q  <= port_d;
      vfid_q  <= vfid_d;
      rsid_q  <= rsid_d;
      route_q <= route_d;
      csid_q  <= csid_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
    end
  end

  // Table storage survives reset; reads return pre-write data.
  always_ff @(posedge aclk) begin
    if (sess_we)  sess_ram[wr_idx]  <= sess_wdata;
    if (route_we) route_ram[wr_idx] <= route_q;
    rsid_rd_q  <= sess_ram[sid_addr];
    route_rd_q <= route_ram[sid_addr];
  end

  assign rsid_out      = rsid_rd_q;
  assign route_id_out  = route_rd_q;
  assign open_ok_cnt   = ok_q;
  assign open_fail_cnt = fail_q;

endmodule

// File: tb/tb_tcp_conn_table.sv
// Randomised bench for tcp_conn_table against a sid-keyed table model.
// Inputs change at posedge+1, outputs are sampled on the falling edge.
module tb_tcp_conn_table;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  metaIntf #(.W(76)) s_open_req ();
  metaIntf #(.W(48)) m_open_req ();
  metaIntf #(.W(65)) s_open_rsp ();
  metaIntf #(.W(69)) m_open_rsp ();
  metaIntf #(.W(16)) s_close_req ();
  metaIntf #(.W(16)) m_close_req ();

  logic [9:0]  sid_addr;
  logic [15:0] rsid_out;
  logic [13:0] route_id_out;
  logic [31:0] open_ok_cnt;
  logic [31:0] open_fail_cnt;

  tcp_conn_table #(
    .SESSION_ORDER(10),
    .RSID_BITS(14),
    .ROUTE_BITS(14)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_open_req(s_open_req),
    .m_open_req(m_open_req),
    .s_open_rsp(s_open_rsp),
    .m_open_rsp(m_open_rsp),
    .s_close_req(s_close_req),
    .m_close_req(m_close_req),
    .sid_addr(sid_addr),
    .rsid_out(rsid_out),
    .route_id_out(route_id_out),
    .open_ok_cnt(open_ok_cnt),
    .open_fail_cnt(open_fail_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: what each table entry should hold, and expected counters.
  logic [15:0] sess_ref [int];
  logic [13:0] route_ref [int];
  logic [31:0] ok_ref = 0;
  logic [31:0] fail_ref = 0;

  logic [31:0] cur_ip;
  logic [15:0] cur_port;
  logic [3:0]  cur_vfid;
  logic [13:0] cur_rsid;
  logic [13:0] cur_route;

  task automatic drive_open(input logic [31:0] ip, input logic [15:0] port,
                            input logic [3:0] vf, input logic [5:0] pid,
                            input logic [3:0] dest, input logic [13:0] route);
    cur_ip = ip;
    cur_port = port;
    cur_vfid = vf;
    cur_rsid = {vf, pid, dest};
    cur_route = route;
    s_open_req.data = {ip, port, vf, pid, dest, route};
    s_open_req.valid = 1'b1;
  endtask

  task automatic wait_open_accept(output bit hs);
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge aclk);
      hs = s_open_req.ready;
      @(posedge aclk); #1;
    end
    s_open_req.valid = 1'b0;
  endtask

  task automatic finish_open(input logic [15:0] sid, input bit succ,
                             input int st1, input int st2);
    bit hs;
    int idx;
    wait_open_accept(hs);
    n_cmp++;
    if (!hs) begin
      n_bad++;
      $display("FAIL open_accept: ready not seen in 20 cycles");
    end
    m_open_req.ready = 1'b0;
    for (int i = 0; i <= st1; i++) begin
      if (i == st1) m_open_req.ready = 1'b1;
      @(negedge aclk);
      n_cmp++;
      if ({m_open_req.valid, m_open_req.data} !== {1'b1, cur_ip, cur_port}) begin
        n_bad++;
        $display("FAIL m_open_req: got v=%0b d=%h want v=1 d=%h",
                 m_open_req.valid, m_open_req.data, {cur_ip, cur_port});
      end
      @(posedge aclk); #1;
    end
    m_open_req.ready = 1'b0;
    idx = int'(sid[9:0]);
    sid_addr = sid[9:0];
    s_open_rsp.data = {sid, succ, cur_ip, cur_port};
    s_open_rsp.valid = 1'b1;
    m_open_rsp.ready = 1'b0;
    for (int i = 0; i <= st2; i++) begin
      if (i == st2) m_open_rsp.ready = 1'b1;
      @(negedge aclk);
      n_cmp++;
      if ({m_open_rsp.valid, s_open_rsp.ready, m_open_rsp.data} !==
          {1'b1, (i == st2), sid, succ, cur_ip, cur_port, cur_vfid}) begin
        n_bad++;
        $display("FAIL open_rsp: got v=%0b r=%0b d=%h want r=%0b d=%h",
                 m_open_rsp.valid, s_open_rsp.ready, m_open_rsp.data,
                 (i == st2), {sid, succ, cur_ip, cur_port, cur_vfid});
      end
      if (i > 0 && sess_ref.exists(idx)) begin
        n_cmp++;
        if (rsid_out !== sess_ref[idx]) begin
          n_bad++;
          $display("FAIL early_write: entry %0d got %h want %h",
                   idx, rsid_out, sess_ref[idx]);
        end
      end
      @(posedge aclk); #1;
    end
    s_open_rsp.valid = 1'b0;
    m_open_rsp.ready = 1'b0;
    if (succ && sid < 16'd1024) begin
      sess_ref[idx] = {2'b01, cur_rsid};
      route_ref[idx] = cur_route;
      ok_ref++;
    end else begin
      fail_ref++;
    end
    @(negedge aclk);
    n_cmp++;
    if (open_ok_cnt !== ok_ref || open_fail_cnt !== fail_ref) begin
      n_bad++;
      $display("FAIL counters: got ok=%0d fail=%0d want ok=%0d fail=%0d",
               open_ok_cnt, open_fail_cnt, ok_ref, fail_ref);
    end
    @(posedge aclk); #1;
  endtask

  task automatic do_close(input logic [15:0] sid, input int st,
                          input bit open_pending);
    bit hs;
    hs = 1'b0;
    s_close_req.data = sid;
    s_close_req.valid = 1'b1;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge aclk);
      hs = s_close_req.ready;
      if (hs && open_pending) begin
        n_cmp++;
        if (s_open_req.ready !== 1'b0) begin
          n_bad++;
          $display("FAIL close_prio: open ready=%0b want 0", s_open_req.ready);
        end
      end
      @(posedge aclk); #1;
    end
    s_close_req.valid = 1'b0;
    n_cmp++;
    if (!hs) begin
      n_bad++;
      $display("FAIL close_accept: ready not seen in 20 cycles");
    end
    m_close_req.ready = 1'b0;
    for (int i = 0; i <= st; i++) begin
      if (i == st) m_close_req.ready = 1'b1;
      @(negedge aclk);
      n_cmp++;
      if ({m_close_req.valid, m_close_req.data} !== {1'b1, sid}) begin
        n_bad++;
        $display("FAIL m_close_req: got v=%0b d=%h want v=1 d=%h",
                 m_close_req.valid, m_close_req.data, sid);
      end
      @(posedge aclk); #1;
    end
    m_close_req.ready = 1'b0;
    if (sid < 16'd1024) sess_ref[int'(sid)] = 16'h0000;
  endtask

  task automatic check_lookup(input int idx);
    sid_addr = idx[9:0];
    @(posedge aclk); #1;
    @(negedge aclk);
    if (sess_ref.exists(idx)) begin
      n_cmp++;
      if (rsid_out !== sess_ref[idx]) begin
        n_bad++;
        $display("FAIL lookup_rsid: entry %0d got %h want %h",
                 idx, rsid_out, sess_ref[idx]);
      end
    end
    if (route_ref.exists(idx)) begin
      n_cmp++;
      if (route_id_out !== route_ref[idx]) begin
        n_bad++;
        $display("FAIL lookup_route: entry %0d got %h want %h",
                 idx, route_id_out, route_ref[idx]);
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    n_cmp++;
    if ({s_open_req.ready, m_open_req.valid, s_open_rsp.ready,
         m_open_rsp.valid, s_close_req.ready, m_close_req.valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_hs: handshake outputs not all 0");
    end
    n_cmp++;
    if ({m_open_req.data, m_open_rsp.data, m_close_req.data} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0",
               {m_open_req.data, m_open_rsp.data, m_close_req.data});
    end
    n_cmp++;
    if (open_ok_cnt !== 32'd0 || open_fail_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got ok=%0d fail=%0d want 0",
               open_ok_cnt, open_fail_cnt);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_basic_open;
    drive_open(32'h0A000001, 16'd5000, 4'd1, 6'd2, 4'd3, 14'h15);
    finish_open(16'd7, 1'b1, 2, 1);
    check_lookup(7);
    @(negedge aclk);
    n_cmp++;
    if (rsid_out !== 16'h4423 || route_id_out !== 14'h15
        || open_ok_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL basic_open: got rsid=%h route=%h ok=%0d want 4423 15 1",
               rsid_out, route_id_out, open_ok_cnt);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_fail_rsp;
    drive_open(32'hC0A80002, 16'd80, 4'd2, 6'd5, 4'd1, 14'h2A);
    finish_open(16'd9, 1'b1, 0, 0);
    drive_open(32'hC0A80003, 16'd81, 4'd3, 6'd7, 4'd2, 14'h3B);
    finish_open(16'd9, 1'b0, 1, 0);
    check_lookup(9);
  endtask

  task automatic test_out_of_range;
    drive_open(32'h0A0A0A0A, 16'd443, 4'd4, 6'd9, 4'd5, 14'h111);
    finish_open(16'd0, 1'b1, 0, 0);
    drive_open(32'h0B0B0B0B, 16'd444, 4'd5, 6'd10, 4'd6, 14'h222);
    finish_open(16'h0400, 1'b1, 0, 2);
    check_lookup(0);
  endtask

  task automatic test_close_priority;
    drive_open(32'h0A000009, 16'd6000, 4'd6, 6'd11, 4'd7, 14'h99);
    do_close(16'd7, 1, 1'b1);
    finish_open(16'd12, 1'b1, 0, 0);
    check_lookup(7);
    check_lookup(12);
  endtask

  task automatic test_unsolicited;
    s_open_rsp.data = {16'd3, 1'b1, 32'hDEADBEEF, 16'd1};
    s_open_rsp.valid = 1'b1;
    m_open_rsp.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      n_cmp++;
      if (s_open_rsp.ready !== 1'b0 || m_open_rsp.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL unsolicited: got r=%0b v=%0b want 0 0",
                 s_open_rsp.ready, m_open_rsp.valid);
      end
      @(posedge aclk); #1;
    end
    s_open_rsp.valid = 1'b0;
    m_open_rsp.ready = 1'b0;
  endtask

  task automatic test_backpressure;
    drive_open(32'h0A000014, 16'd20, 4'd7, 6'd1, 4'd8, 14'h140);
    finish_open(16'd20, 1'b1, 0, 0);
    drive_open(32'h0A000015, 16'd21, 4'd8, 6'd3, 4'd9, 14'h150);
    finish_open(16'd20, 1'b1, 4, 10);
    check_lookup(20);
  endtask

  task automatic test_reset_mid;
    bit hs;
    drive_open(32'h0A000030, 16'd30, 4'd9, 6'd4, 4'd10, 14'h300);
    wait_open_accept(hs);
    m_open_req.ready = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (!hs || m_open_req.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_send: got hs=%0b v=%0b want 1 1",
               hs, m_open_req.valid);
    end
    @(posedge aclk); #1 aresetn = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    ok_ref = 0;
    fail_ref = 0;
    @(negedge aclk);
    n_cmp++;
    if (m_open_req.valid !== 1'b0 || open_ok_cnt !== 32'd0
        || open_fail_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got v=%0b ok=%0d fail=%0d want 0 0 0",
               m_open_req.valid, open_ok_cnt, open_fail_cnt);
    end
    @(posedge aclk); #1;
    check_lookup(7);
    check_lookup(9);
    check_lookup(12);
    check_lookup(20);
  endtask

  task automatic test_random;
    logic [15:0] sid;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        sid = 16'($urandom_range(0, 15));
        do_close(sid, int'($urandom_range(0, 2)), 1'b0);
      end else begin
        drive_open($urandom, 16'($urandom), 4'($urandom), 6'($urandom),
                   4'($urandom), 14'($urandom));
        if ($urandom_range(0, 9) == 0)
          sid = 16'h0400 + 16'($urandom_range(0, 15));
        else
          sid = 16'($urandom_range(0, 15));
        finish_open(sid, ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end
    for (int i = 0; i < 16; i++) check_lookup(i);
  endtask

  initial begin
    s_open_req.valid = 1'b0;
    s_open_req.data = '0;
    m_open_req.ready = 1'b0;
    s_open_rsp.valid = 1'b0;
    s_open_rsp.data = '0;
    m_open_rsp.ready = 1'b0;
    s_close_req.valid = 1'b0;
    s_close_req.data = '0;
    m_close_req.ready = 1'b0;
    sid_addr = '0;
    test_reset;
    test_basic_open;
    test_fail_rsp;
    test_out_of_range;
    test_close_priority;
    test_unsolicited;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcp_conn_table.md
TCP_CONN_TABLE -- requirements
Module: tcp_conn_table

Interface
REQ-001 SHALL have parameter SESSION_ORDER, default 10, log2 of session table depth (1024 entries).
REQ-002 SHALL have parameter RSID_BITS, default 14, width of {vfid,pid,dest} remote-session id.
REQ-003 SHALL have parameter ROUTE_BITS, default 14, width of stored route id.
REQ-004 SHALL have clock aclk and reset aresetn, synchronous, active-low; clock aclk.
REQ-005 SHALL have aclk  input  1  clock.
REQ-006 SHALL have aresetn  input  1  synchronous active-low reset.
REQ-007 SHALL have s_open_req  metaIntf.s  -  user active-open request {ip_addr 32, ip_port 16, vfid, pid, dest, route_id ROUTE_BITS}.
REQ-008 SHALL have m_open_req  metaIntf.m  -  request to TCP stack {ip_addr 32, ip_port 16}.
REQ-009 SHALL have s_open_rsp  metaIntf.s  -  stack response {sid 16, success 1, ip_addr 32, ip_port 16}.
REQ-010 SHALL have m_open_rsp  metaIntf.m  -  user response {sid 16, success 1, ip_addr, ip_port, vfid}.
REQ-011 SHALL have s_close_req  metaIntf.s  -  user close {sid 16}; m_close_req  metaIntf.m  -  close to stack {sid 16}.
REQ-012 SHALL have sid_addr  input  SESSION_ORDER  lookup address; rsid_out  output  16  {1'b0, valid, rsid}; route_id_out  output  ROUTE_BITS.
REQ-013 SHALL have open_ok_cnt, open_fail_cnt  output  32 each  statistics counters.

Function
REQ-014 FSM states SHALL be ST_IDLE, ST_SEND, ST_RSP_WAIT, ST_CLOSE_SEND.
REQ-015 ST_IDLE: s_close_req.valid SHALL take priority; assert s_close_req.ready, latch sid, go ST_CLOSE_SEND.
REQ-016 ST_IDLE, no close pending, s_open_req.valid: assert ready one cycle, latch all fields, rsid = {vfid,pid,dest}, go ST_SEND.
REQ-017 ST_SEND: m_open_req.valid=1 with latched ip_addr/ip_port; on ready go ST_RSP_WAIT.
REQ-018 ST_RSP_WAIT: s_open_rsp.ready = m_open_rsp.ready, m_open_rsp.valid = s_open_rsp.valid, data passed through combinationally, vfid from latch; on handshake go ST_IDLE.
REQ-019 On ST_RSP_WAIT handshake with success=1 and sid[15:SESSION_ORDER]==0, session RAM and route RAM SHALL be written at sid[SESSION_ORDER-1:0] with {2'b01, rsid} and latched route_id in that cycle.
REQ-020 success=1 with out-of-range sid SHALL be forwarded unchanged, no table write, counted as open_fail_cnt.
REQ-021 ST_CLOSE_SEND: m_close_req.valid=1 with latched sid; on ready write 16'h0000 to session entry if sid in range (route entry unchanged), go ST_IDLE.
REQ-022 open_ok_cnt SHALL increment on each in-range success handshake; open_fail_cnt on each success=0 or out-of-range handshake; both wrap 2^32-1 -> 0.
REQ-023 Lookup port SHALL be registered: rsid_out/route_id_out reflect sid_addr sampled one cycle earlier; read-first on same-cycle collision (old data).
REQ-024 Only one request outstanding; s_open_req.ready and s_close_req.ready SHALL be 0 outside ST_IDLE.
REQ-025 m_open_req/m_close_req data SHALL be held stable while valid and not ready.
REQ-026 Unsolicited s_open_rsp outside ST_RSP_WAIT SHALL be back-pressured (ready=0), not dropped.

Reset
REQ-027 On aresetn=0 at a clock edge: state ST_IDLE, all valid/ready outputs 0, counters 0, latched route_id 0.
REQ-028 Reset SHALL NOT clear RAM contents; reset mid-transaction abandons it without table write.
REQ-029 All outputs SHALL be 0 in the first cycle after reset except RAM read data (undefined until written).

Verification
REQ-030 Open ip 0x0A000001:5000 vfid=1 pid=2 dest=3 route=0x15; stack sid=7 success=1 -> user rsp success=1 sid=7; sid_addr=7 two cycles later -> rsid_out valid bit=1 with rsid {1,2,3}, route_id_out=0x15, open_ok_cnt=1.
REQ-031 Stack rsp success=0 sid=9 -> forwarded success=0, entry 9 unchanged, open_fail_cnt=1.
REQ-032 Stack rsp success=1 sid=0x0400 (out of range) -> forwarded, no write, open_fail_cnt increments.
REQ-033 Close sid=7 asserted same cycle as open request -> close served first, m_close_req sid=7, entry 7 reads 0x0000; open then proceeds.
REQ-034 m_open_rsp.ready held 0 for 10 cycles during ST_RSP_WAIT -> s_open_rsp.ready=0, no write until handshake; reset asserted in ST_SEND -> ST_IDLE, m_open_req.valid=0 next cycle.
